// File: rtl/image_stream_source.sv
// image_stream_source
// Raster pixel transmitter for the 3x3 window generators. On Start it walks one
// IMG_WIDHT x IMG_HEIGHT frame in row-major order, reading a synchronous
// single-port image RAM, and emits each pixel as a Data_Out/Valid_Out beat
// with row (Last_Col) and frame (Last_Pixel) markers.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   Start      in   frame request, only looked at in IDLE
//   Pause      in   suppresses this cycle's RAM read while running
//   Mem_Rd_En  out  RAM read strobe
//   Mem_Addr   out  RAM read address (row*IMG_WIDHT + col)
//   Mem_Data   in   RAM read data, one cycle after Mem_Rd_En
//   Data_Out   out  pixel word, holds when Valid_Out is low
//   Valid_Out  out  pixel beat qualifier
//   Last_Col   out  last pixel of a row
//   Last_Pixel out  last pixel of the frame
//   Busy       out  high in RUN and DRAIN
//   Done       out  one-cycle pulse after the frame's last beat
module image_stream_source #(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDHT  = 220,
  parameter int IMG_HEIGHT = 220,
  parameter int ADDR_W     = $clog2(IMG_WIDHT * IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic                  Pause,
  output logic                  Mem_Rd_En,
  output logic [ADDR_W-1:0]     Mem_Addr,
  input  logic [DATA_WIDHT-1:0] Mem_Data,
  output logic [DATA_WIDHT-1:0] Data_Out,
  output logic                  Valid_Out,
  output logic                  Last_Col,
  output logic                  Last_Pixel,
  output logic                  Busy,
  output logic                  Done
);

  localparam int COL_W = (IMG_WIDHT > 1) ? $clog2(IMG_WIDHT) : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDHT - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              drain_q, drain_d;

  logic rd_en_s, busy_s, done_s;
  logic col_last_s, pix_last_s;

  // Stage 1: flags travelling alongside the RAM access.
  logic v1_q, lc1_q, lp1_q;
  // Stage 2: output register.
  logic [DATA_WIDHT-1:0] data_q;
  logic valid_q, lc_q, lp_q;

  assign col_last_s = (col_q == COL_LAST);
  assign pix_last_s = col_last_s && (row_q == ROW_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = Start ? ST_RUN : ST_IDLE;
      ST_RUN:   state_d = (rd_en_s && pix_last_s) ? ST_DRAIN : ST_RUN;
      // Two DRAIN cycles let the final read clear both pipeline stages.
      ST_DRAIN: state_d = drain_q ? ST_DONE : ST_DRAIN;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs. The read strobe follows Pause in the same cycle so
  // a paused cycle turns into a Valid_Out bubble exactly two cycles later.
  always_comb begin
    rd_en_s = (state_q == ST_RUN) && !Pause;
    busy_s  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done_s  = (state_q == ST_DONE);
  end

  // Raster counter next-state; counters freeze on the final read so the
  // address never runs past the frame.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    drain_d = (state_q == ST_DRAIN) && !drain_q;
    if ((state_q == ST_IDLE) && Start) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (rd_en_s && !pix_last_s) begin
      addr_d = addr_q + ADDR_W'(1);
      if (col_last_s) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else begin
      col_d = col_q;
    end
  end

  // Counters and the two-stage read pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      drain_q <= 1'b0;
      v1_q    <= 1'b0;
      lc1_q   <= 1'b0;
      lp1_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      lc_q    <= 1'b0;
      lp_q    <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      v1_q    <= rd_en_s;
      lc1_q   <= rd_en_s && col_last_s;
      lp1_q   <= rd_en_s && pix_last_s;
      valid_q <= v1_q;
      lc_q    <= lc1_q;
      lp_q    <= lp1_q;
      // Only capture RAM data for issued reads; otherwise hold the last pixel.
      if (v1_q) begin
        data_q <= Mem_Data;
      end
    end
  end

  assign Mem_Rd_En  = rd_en_s;
  assign Mem_Addr   = addr_q;
  assign Data_Out   = data_q;
  assign Valid_Out  = valid_q;
  assign Last_Col   = lc_q;
  assign Last_Pixel = lp_q;
  assign Busy       = busy_s;
  assign Done       = done_s;

endmodule

// File: tb/tb_image_stream_source.sv
// Directed bench for image_stream_source with a 4x3 frame and RAM[i] = i+100.
// Offsets below are cycles after the cycle in which Start is sampled.
module tb_image_stream_source;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DW = 32;
  localparam int AW = $clog2(W * H);

  logic          clk = 1'b0;
  logic          rst;
  logic          Start;
  logic          Pause;
  logic          Mem_Rd_En;
  logic [AW-1:0] Mem_Addr;
  logic [DW-1:0] Mem_Data = '0;
  logic [DW-1:0] Data_Out;
  logic          Valid_Out;
  logic          Last_Col;
  logic          Last_Pixel;
  logic          Busy;
  logic          Done;

  int checks   = 0;
  int failures = 0;
  int beat;
  int dones;

  always #5 clk = ~clk;

  image_stream_source #(
    .DATA_WIDHT(DW),
    .IMG_WIDHT (W),
    .IMG_HEIGHT(H),
    .ADDR_W    (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Start     (Start),
    .Pause     (Pause),
    .Mem_Rd_En (Mem_Rd_En),
    .Mem_Addr  (Mem_Addr),
    .Mem_Data  (Mem_Data),
    .Data_Out  (Data_Out),
    .Valid_Out (Valid_Out),
    .Last_Col  (Last_Col),
    .Last_Pixel(Last_Pixel),
    .Busy      (Busy),
    .Done      (Done)
  );

  // Synchronous image RAM model: RAM[i] = i + 100.
  always @(posedge clk) begin
    if (Mem_Rd_En) Mem_Data <= DW'(Mem_Addr) + 32'd100;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then settle before checking.
  task automatic tick(input logic s, input logic p, input logic r);
    @(negedge clk);
    Start = s;
    Pause = p;
    rst   = r;
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rd"},   32'(Mem_Rd_En),  32'd0);
    chk({tag, "_addr"}, 32'(Mem_Addr),   32'd0);
    chk({tag, "_data"}, Data_Out,        32'd0);
    chk({tag, "_vld"},  32'(Valid_Out),  32'd0);
    chk({tag, "_lc"},   32'(Last_Col),   32'd0);
    chk({tag, "_lp"},   32'(Last_Pixel), 32'd0);
    chk({tag, "_busy"}, 32'(Busy),       32'd0);
    chk({tag, "_done"}, 32'(Done),       32'd0);
  endtask

  initial begin
    rst = 1'b1; Start = 1'b0; Pause = 1'b0;

    // Reset, including reset and Start together (reset wins).
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    chk_quiet("reset");
    tick(1'b0, 1'b0, 1'b0);
    chk_quiet("reset_start");
    tick(1'b0, 1'b1, 1'b0);
    chk("idle_pause_rd", 32'(Mem_Rd_En), 32'd0);

    // Frame with no pauses.
    tick(1'b1, 1'b0, 1'b0);
    for (int off = 1; off <= 17; off++) begin
      logic exp_rd, exp_v;
      tick(1'b0, 1'b0, 1'b0);
      exp_rd = (off >= 1) && (off <= 12);
      exp_v  = (off >= 3) && (off <= 14);
      chk($sformatf("s1_rd@%0d", off), 32'(Mem_Rd_En), 32'(exp_rd));
      if (exp_rd) chk($sformatf("s1_addr@%0d", off), 32'(Mem_Addr), 32'(off - 1));
      chk($sformatf("s1_vld@%0d", off), 32'(Valid_Out), 32'(exp_v));
      if (exp_v) chk($sformatf("s1_data@%0d", off), Data_Out, 32'(100 + off - 3));
      chk($sformatf("s1_lc@%0d", off), 32'(Last_Col), 32'(off == 6 || off == 10 || off == 14));
      chk($sformatf("s1_lp@%0d", off), 32'(Last_Pixel), 32'(off == 14));
      chk($sformatf("s1_done@%0d", off), 32'(Done), 32'(off == 15));
      chk($sformatf("s1_busy@%0d", off), 32'(Busy), 32'(exp_v || exp_rd));
    end
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);

    // Frame with Pause at offsets 2 and 5: bubbles at 4 and 7, Done at 17.
    tick(1'b1, 1'b0, 1'b0);
    beat = 0;
    for (int off = 1; off <= 18; off++) begin
      logic p;
      p = (off == 2) || (off == 5);
      tick(1'b0, p, 1'b0);
      chk($sformatf("s2_rd@%0d", off), 32'(Mem_Rd_En), 32'((off <= 14) && !p));
      if (off == 4) begin
        chk("s2_bubble4", 32'(Valid_Out), 32'd0);
        chk("s2_hold4", Data_Out, 32'd100);
      end
      if (off == 7) begin
        chk("s2_bubble7", 32'(Valid_Out), 32'd0);
        chk("s2_hold7", Data_Out, 32'd102);
      end
      if (Valid_Out) begin
        chk($sformatf("s2_data@%0d", off), Data_Out, 32'(100 + beat));
        beat++;
      end
      chk($sformatf("s2_lp@%0d", off), 32'(Last_Pixel), 32'(off == 16));
      chk($sformatf("s2_done@%0d", off), 32'(Done), 32'(off == 17));
    end
    chk("s2_beats", 32'(beat), 32'd12);
    tick(1'b0, 1'b0, 1'b0);

    // Start held high: frames every 16 cycles, one IDLE cycle after each Done.
    tick(1'b1, 1'b0, 1'b0);
    beat = 0;
    dones = 0;
    for (int off = 1; off <= 50; off++) begin
      tick(off < 47, 1'b0, 1'b0);
      if (Valid_Out) begin
        chk($sformatf("s3_data@%0d", off), Data_Out, 32'(100 + (beat % 12)));
        beat++;
      end
      if (Done) dones++;
      if (off == 16 || off == 32) begin
        chk($sformatf("s3_gap_rd@%0d", off), 32'(Mem_Rd_En), 32'd0);
        chk($sformatf("s3_gap_busy@%0d", off), 32'(Busy), 32'd0);
      end
      if (off == 17 || off == 33) begin
        chk($sformatf("s3_restart_rd@%0d", off), 32'(Mem_Rd_En), 32'd1);
        chk($sformatf("s3_restart_addr@%0d", off), 32'(Mem_Addr), 32'd0);
      end
    end
    chk("s3_dones", 32'(dones), 32'd3);
    chk("s3_beats", 32'(beat), 32'd36);
    chk("s3_idle_busy", 32'(Busy), 32'd0);

    // Reset mid-frame (offset 7), restart two cycles later.
    tick(1'b1, 1'b0, 1'b0);
    for (int off = 1; off <= 6; off++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    chk_quiet("s4_after_rst");
    tick(1'b1, 1'b0, 1'b0);
    chk("s4_start_vld", 32'(Valid_Out), 32'd0);
    chk("s4_start_busy", 32'(Busy), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    chk("s4_rd0", 32'(Mem_Rd_En), 32'd1);
    chk("s4_addr0", 32'(Mem_Addr), 32'd0);
    chk("s4_vld_a", 32'(Valid_Out), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    chk("s4_addr1", 32'(Mem_Addr), 32'd1);
    chk("s4_vld_b", 32'(Valid_Out), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    chk("s4_vld_first", 32'(Valid_Out), 32'd1);
    chk("s4_data_first", Data_Out, 32'd100);
    dones = 0;
    for (int off = 1; off <= 16; off++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (Done) dones++;
    end
    chk("s4_dones", 32'(dones), 32'd1);

    // Start pulsed during RUN, DRAIN and DONE: ignored.
    tick(1'b1, 1'b0, 1'b0);
    dones = 0;
    for (int off = 1; off <= 25; off++) begin
      tick((off == 5) || (off == 13) || (off == 14) || (off == 15), 1'b0, 1'b0);
      if (Done) dones++;
      if (off >= 16) chk($sformatf("s5_no_restart@%0d", off), 32'(Mem_Rd_En), 32'd0);
    end
    chk("s5_dones", 32'(dones), 32'd1);
    chk("s5_busy", 32'(Busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
